cond_subtractor_pipe: RTL and testbench
=======================================

COND_SUBTRACTOR_PIPE -- requirements
Module: cond_subtractor_pipe

Interface
REQ-001 SHALL have parameter INPUT_LEN, default 8: operand and difference width.
REQ-002 SHALL have parameter BLOCK_LEN, default 4: conditional-select block width; INPUT_LEN = 2*BLOCK_LEN.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  operand pair presented.
REQ-006 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-007 SHALL have port a  in  INPUT_LEN  minuend.
REQ-008 SHALL have port b  in  INPUT_LEN  subtrahend.
REQ-009 SHALL have port out_valid  out  1  result presented.
REQ-010 SHALL have port out_ready  in  1  consumer accepts result this cycle.
REQ-011 SHALL have port diff  out  INPUT_LEN  difference.
REQ-012 SHALL have port bout  out  1  borrow out; 1 iff a < b unsigned.

Function
REQ-013 SHALL compute diff = (a - b) mod 2^INPUT_LEN and bout = (a < b), unsigned.
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 Stage 1 SHALL register lower-block difference plus lower borrow, and upper-block differences and borrows for both borrow-in = 0 and = 1.
REQ-016 Stage 2 SHALL select upper variant using registered lower borrow and register diff, bout, out_valid.
REQ-017 Latency SHALL be 2 cycles: operand accepted at edge N appears with out_valid at edge N+2 when not stalled.
REQ-018 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-019 Stage 2 SHALL load when !out_valid || out_ready; stage 1 SHALL load when stage 1 is empty or stage 2 loads.
REQ-020 in_ready SHALL equal the stage-1 load condition (combinational path from out_ready permitted).
REQ-021 While out_valid && !out_ready, diff and bout SHALL hold stable; no result dropped or duplicated.
REQ-022 With two operations in flight and out_ready low, in_ready SHALL be 0.
REQ-023 Simultaneous output acceptance and input acceptance in the same cycle SHALL both succeed, preserving order.
REQ-024 Stage registers SHALL not load data when the corresponding valid does not advance; bubbles SHALL propagate as out_valid = 0.

Reset
REQ-025 On rst high, out_valid and stage-1 valid SHALL clear immediately; diff = 0, bout = 0.
REQ-026 Reset mid-operation SHALL discard all in-flight results; no out_valid until a new accepted input reaches stage 2.
REQ-027 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-028 Macro COND_SUB_SATURATE_EN: when defined, diff SHALL be 0 whenever bout = 1; bout unchanged; latency unchanged.
REQ-029 When COND_SUB_SATURATE_EN is undefined, diff SHALL wrap per REQ-013.

Structure
REQ-030 INPUT_LEN and BLOCK_LEN defaults SHALL live in the shared adder defines file, common with the conditional adder.
REQ-031 One sub-module cond_sub_block SHALL compute a BLOCK_LEN-bit block difference and borrow for both borrow-in values; instantiated twice (lower uses borrow-in 0 result only).

Verification
REQ-032 a=0x53, b=0x21, out_ready=1 -> after 2 cycles diff=0x32, bout=0.
REQ-033 a=0x10, b=0x01 (lower borrow into upper) -> diff=0x0F, bout=0.
REQ-034 a=0x00, b=0x01 -> diff=0xFF, bout=1; with COND_SUB_SATURATE_EN diff=0x00, bout=1.
REQ-035 Issue 3 back-to-back operands with out_ready=0 -> in_ready falls after 2 accepted; release out_ready -> results emerge in order, third accepted, none lost.
REQ-036 Assert rst with 2 operations in flight -> out_valid=0 immediately, no stale result after rst release, in_ready=1.
REQ-037 Random 10k operand pairs with random in_valid/out_ready -> every result matches REQ-013, order preserved.

Source files
------------

// File: rtl/cond_subtractor_pipe_pkg.sv
// Shared adder/subtractor defines: default operand and block widths.
// Common to the conditional adder and conditional subtractor pipelines.
package cond_subtractor_pipe_pkg;
   localparam int INPUT_LEN_DEF = 8;
   localparam int BLOCK_LEN_DEF = 4;
endpackage

// File: rtl/cond_subtractor_pipe_block.sv
// cond_sub_block: BLOCK_LEN-bit difference and borrow, computed for
// both borrow-in values so the caller can select late.
module cond_sub_block
   import cond_subtractor_pipe_pkg::*;
#(
   parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
   input  logic [BLOCK_LEN-1:0] a_i,
   input  logic [BLOCK_LEN-1:0] b_i,
   output logic [BLOCK_LEN-1:0] d0_o,
   output logic                 bo0_o,
   output logic [BLOCK_LEN-1:0] d1_o,
   output logic                 bo1_o
);

   logic [BLOCK_LEN:0] r0;
   logic [BLOCK_LEN:0] r1;
   logic [BLOCK_LEN:0] one;

   assign one = {{BLOCK_LEN{1'b0}}, 1'b1};

   // Extra MSB goes high exactly when the block result is negative.
   assign r0 = {1'b0, a_i} - {1'b0, b_i};
   assign r1 = {1'b0, a_i} - {1'b0, b_i} - one;

   assign d0_o  = r0[BLOCK_LEN-1:0];
   assign bo0_o = r0[BLOCK_LEN];
   assign d1_o  = r1[BLOCK_LEN-1:0];
   assign bo1_o = r1[BLOCK_LEN];

endmodule

// File: rtl/cond_subtractor_pipe.sv
// Two-stage conditional-select subtractor with valid/ready flow control.
// Define COND_SUB_SATURATE_EN to clamp diff to 0 on underflow.
module cond_subtractor_pipe
   import cond_subtractor_pipe_pkg::*;
#(
   parameter int INPUT_LEN = INPUT_LEN_DEF,
   parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INPUT_LEN-1:0] a,
   input  logic [INPUT_LEN-1:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INPUT_LEN-1:0] diff,
   output logic                 bout
);

   localparam int HI_LEN = INPUT_LEN - BLOCK_LEN;

   logic [BLOCK_LEN-1:0] lo_d0;
   logic                 lo_b0;
   logic [BLOCK_LEN-1:0] unused_lo_d1;
   logic                 unused_lo_b1;
   logic [HI_LEN-1:0]    hi_d0;
   logic                 hi_b0;
   logic [HI_LEN-1:0]    hi_d1;
   logic                 hi_b1;

   cond_sub_block #(.BLOCK_LEN(BLOCK_LEN)) u_lo (
      .a_i   (a[BLOCK_LEN-1:0]),
      .b_i   (b[BLOCK_LEN-1:0]),
      .d0_o  (lo_d0),
      .bo0_o (lo_b0),
      .d1_o  (unused_lo_d1),
      .bo1_o (unused_lo_b1)
   );

   cond_sub_block #(.BLOCK_LEN(HI_LEN)) u_hi (
      .a_i   (a[INPUT_LEN-1:BLOCK_LEN]),
      .b_i   (b[INPUT_LEN-1:BLOCK_LEN]),
      .d0_o  (hi_d0),
      .bo0_o (hi_b0),
      .d1_o  (hi_d1),
      .bo1_o (hi_b1)
   );

   logic                 s1_v_q;
   logic [BLOCK_LEN-1:0] s1_lo_d_q;
   logic                 s1_lo_b_q;
   logic [HI_LEN-1:0]    s1_hi_d0_q;
   logic                 s1_hi_b0_q;
   logic [HI_LEN-1:0]    s1_hi_d1_q;
   logic                 s1_hi_b1_q;

   logic                 ov_q;
   logic [INPUT_LEN-1:0] diff_q;
   logic                 bout_q;
   logic [INPUT_LEN-1:0] diff_d;
   logic                 bout_d;
   logic                 ld1;
   logic                 ld2;

   assign ld2      = !ov_q || out_ready;
   assign ld1      = !s1_v_q || ld2;
   assign in_ready = ld1;

   always_comb begin
      bout_d = s1_lo_b_q ? s1_hi_b1_q : s1_hi_b0_q;
      diff_d = s1_lo_b_q ? {s1_hi_d1_q, s1_lo_d_q}
                         : {s1_hi_d0_q, s1_lo_d_q};
`ifdef COND_SUB_SATURATE_EN
      if (bout_d) diff_d = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_lo_d_q  <= '0;
         s1_lo_b_q  <= 1'b0;
         s1_hi_d0_q <= '0;
         s1_hi_b0_q <= 1'b0;
         s1_hi_d1_q <= '0;
         s1_hi_b1_q <= 1'b0;
      end else if (ld1) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_lo_d_q  <= lo_d0;
            s1_lo_b_q  <= lo_b0;
            s1_hi_d0_q <= hi_d0;
            s1_hi_b0_q <= hi_b0;
            s1_hi_d1_q <= hi_d1;
            s1_hi_b1_q <= hi_b1;
         end
      end
   end

   // Data only moves with a valid token so a stalled result stays put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_q   <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (ld2) begin
         ov_q <= s1_v_q;
         if (s1_v_q) begin
            diff_q <= diff_d;
            bout_q <= bout_d;
         end
      end
   end

   assign out_valid = ov_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_cond_subtractor_pipe.sv
// Self-checking bench for cond_subtractor_pipe: vector table, stall,
// reset and randomized scoreboard sequences.
module tb_cond_subtractor_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       bout;

   int tests;
   int fails;

   cond_subtractor_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       bo;
   } res_t;

   vec_t vecs[11];
   res_t sb[$];

   function automatic logic [7:0] sat(input logic [7:0] d, input logic bo);
`ifdef COND_SUB_SATURATE_EN
      return bo ? 8'h00 : d;
`else
      return d;
`endif
   endfunction

   function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
      res_t r;
      logic [8:0] t;
      t = {1'b0, x} - {1'b0, y};
      r.d = sat(t[7:0], t[8]);
      r.bo = t[8];
      return r;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_res(input string name, input res_t e);
      chk({name, " valid"}, int'(out_valid), 1);
      chk({name, " diff"}, int'(diff), int'(e.d));
      chk({name, " bout"}, int'(bout), int'(e.bo));
   endtask

   res_t e0, e1, e2, er;
   logic [7:0] hold_d;
   logic fin, fout;
   int got_n;

   initial begin
      vecs[0]  = '{8'h53, 8'h21, 8'h32, 1'b0};
      vecs[1]  = '{8'h10, 8'h01, 8'h0F, 1'b0};
      vecs[2]  = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[3]  = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[4]  = '{8'h00, 8'hFF, 8'h01, 1'b1};
      vecs[5]  = '{8'h80, 8'h7F, 8'h01, 1'b0};
      vecs[6]  = '{8'h7F, 8'h80, 8'hFF, 1'b1};
      vecs[7]  = '{8'h3C, 8'hC3, 8'h79, 1'b1};
      vecs[8]  = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
      vecs[9]  = '{8'h0F, 8'h10, 8'hFF, 1'b1};
      vecs[10] = '{8'hF0, 8'h0F, 8'hE1, 1'b0};

      tests = 0;
      fails = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      #1;
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst diff", int'(diff), 0);
      chk("rst bout", int'(bout), 0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", int'(in_ready), 1);
      out_ready = 1'b1;

      // Table: one operation at a time, checking two-cycle latency.
      for (int i = 0; i < 11; i++) begin
         a = vecs[i].a;
         b = vecs[i].b;
         in_valid = 1'b1;
         cyc();
         in_valid = 1'b0;
         chk($sformatf("vec%0d early", i), int'(out_valid), 0);
         cyc();
         er.d = sat(vecs[i].d, vecs[i].bo);
         er.bo = vecs[i].bo;
         chk_res($sformatf("vec%0d", i), er);
      end
      cyc();
      chk("drained", int'(out_valid), 0);

      // Stall: three back-to-back operands with the consumer blocked.
      out_ready = 1'b0;
      e0 = model(8'h12, 8'h34);
      e1 = model(8'h90, 8'h09);
      e2 = model(8'h44, 8'h45);
      a = 8'h12; b = 8'h34; in_valid = 1'b1;
      #1;
      chk("stall rdy0", int'(in_ready), 1);
      cyc();
      a = 8'h90; b = 8'h09;
      chk("stall rdy1", int'(in_ready), 1);
      cyc();
      a = 8'h44; b = 8'h45;
      chk("stall full rdy", int'(in_ready), 0);
      chk_res("stall head", e0);
      hold_d = diff;
      cyc();
      cyc();
      chk("stall still full", int'(in_ready), 0);
      chk("stall hold diff", int'(diff), int'(hold_d));
      chk_res("stall hold", e0);
      out_ready = 1'b1;
      #1;
      chk("release rdy", int'(in_ready), 1);
      cyc();
      in_valid = 1'b0;
      chk_res("order1", e1);
      cyc();
      chk_res("order2", e2);
      cyc();
      chk("order none", int'(out_valid), 0);

      // Reset with two operations in flight.
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 8'h77; b = 8'h11;
      cyc();
      a = 8'h01; b = 8'h02;
      cyc();
      in_valid = 1'b0;
      chk("pre-rst valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("async rst valid", int'(out_valid), 0);
      chk("async rst diff", int'(diff), 0);
      chk("async rst bout", int'(bout), 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("rst release rdy", int'(in_ready), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("no stale %0d", i), int'(out_valid), 0);
      end

      // Randomized traffic against a scoreboard.
      got_n = 0;
      for (int i = 0; i < 10000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         a = 8'($urandom);
         b = 8'($urandom);
         #1;
         fin = in_valid && in_ready;
         fout = out_valid && out_ready;
         if (fout) begin
            if (sb.size() == 0) begin
               chk("rand spurious", 1, 0);
            end else begin
               er = sb.pop_front();
               chk("rand diff", int'(diff), int'(er.d));
               chk("rand bout", int'(bout), int'(er.bo));
               got_n++;
            end
         end
         if (fin) sb.push_back(model(a, b));
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && sb.size() != 0; i++) begin
         #1;
         if (out_valid) begin
            er = sb.pop_front();
            chk("drain diff", int'(diff), int'(er.d));
            chk("drain bout", int'(bout), int'(er.bo));
            got_n++;
         end
         cyc();
      end
      chk("rand leftover", sb.size(), 0);
      chk("rand got some", int'(got_n > 1000), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
